// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control decoder and its sequencer.
package alu_pkg;

    // Full {funct7,funct3} encodings for R-type and the shift-immediate
    localparam logic [9:0] FUNCT_AND = 10'h007;
    localparam logic [9:0] FUNCT_XOR = 10'h004;
    localparam logic [9:0] FUNCT_SLL = 10'h001;
    localparam logic [9:0] FUNCT_ADD = 10'h000;
    localparam logic [9:0] FUNCT_SUB = 10'h100;
    localparam logic [9:0] FUNCT_MUL = 10'h008;
    localparam logic [9:0] FUNCT_SRA = 10'h105;

    localparam logic [2:0] FUNCT3_ADDI = 3'b000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_XOR = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_ADD = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SRA = 3'b110;

    localparam logic [1:0] ALUOP_LDST = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_R    = 2'b10;
    localparam logic [1:0] ALUOP_I    = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational {funct7,funct3}/ALUOp to ALU control code decoder.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [9:0] funct_i,
    input  logic [1:0] ALUOp_i,
    output logic [2:0] code_o,
    output logic       is_mul_o,
    output logic       illegal_o
);

    always_comb begin
        code_o    = ALU_ADD;
        is_mul_o  = 1'b0;
        illegal_o = 1'b0;
        case (ALUOp_i)
            ALUOP_LDST: code_o = ALU_ADD;
            ALUOP_BR:   code_o = ALU_SUB;
            ALUOP_R: begin
                case (funct_i)
                    FUNCT_AND: code_o = ALU_AND;
                    FUNCT_XOR: code_o = ALU_XOR;
                    FUNCT_SLL: code_o = ALU_SLL;
                    FUNCT_ADD: code_o = ALU_ADD;
                    FUNCT_SUB: code_o = ALU_SUB;
                    FUNCT_MUL: begin
                        code_o   = ALU_MUL;
                        is_mul_o = 1'b1;
                    end
                    default:   illegal_o = 1'b1;
                endcase
            end
            default: begin
                // I-type: funct7 carries immediate bits except for the shift form
                if (funct_i[2:0] == FUNCT3_ADDI) begin
                    code_o = ALU_ADD;
                end else if (funct_i == FUNCT_SRA) begin
                    code_o = ALU_SRA;
                end else begin
                    illegal_o = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control with valid/ready handshake, flush and multi-cycle MUL sequencing.
module alu_ctrl_seq
    import alu_pkg::*;
#(
    parameter int MUL_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic [9:0] funct_i,
    input  logic [1:0] ALUOp_i,
    input  logic       flush_i,
    output logic [2:0] ALUCtrl_o,
    output logic       ctrl_valid_o,
    output logic       illegal_o,
    output logic       mul_start_o,
    output logic       stall_o
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       alu_q, alu_d;
    logic             vld_q, vld_d;
    logic             ill_q, ill_d;
    logic             start_q, start_d;

    logic [2:0] dec_code;
    logic       dec_mul;
    logic       dec_ill;
    logic       accept;

    alu_ctrl_decode u_decode (
        .funct_i   (funct_i),
        .ALUOp_i   (ALUOp_i),
        .code_o    (dec_code),
        .is_mul_o  (dec_mul),
        .illegal_o (dec_ill)
    );

    assign ready_o = (state_q == ST_IDLE) && !rst_i;
    assign accept  = valid_i && ready_o && !flush_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        alu_d   = alu_q;
        vld_d   = 1'b0;
        ill_d   = 1'b0;
        start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (dec_mul) begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_LOAD;
                        alu_d   = ALU_MUL;
                        start_d = 1'b1;
                    end else begin
                        alu_d = dec_code;
                        vld_d = 1'b1;
                        ill_d = dec_ill;
                    end
                end
            end
            ST_BUSY: begin
                // Flush abandons the multiply silently; the held code stays visible
                if (flush_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    vld_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            alu_q   <= ALU_ADD;
            vld_q   <= 1'b0;
            ill_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alu_q   <= alu_d;
            vld_q   <= vld_d;
            ill_q   <= ill_d;
            start_q <= start_d;
        end
    end

    assign ALUCtrl_o    = alu_q;
    assign ctrl_valid_o = vld_q;
    assign illegal_o    = ill_q;
    assign mul_start_o  = start_q;
    assign stall_o      = (state_q == ST_BUSY);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: two instances (MUL_CYCLES 4 and 1) against a cycle-level reference model.
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst, valid, flush;
    logic [9:0] funct;
    logic [1:0] aluop;

    logic       rdy4, vld4, ill4, st4, stl4;
    logic [2:0] alu4;
    logic       rdy1, vld1, ill1, st1, stl1;
    logic [2:0] alu1;

    int checks = 0;
    int errors = 0;

    // Reference model: busy = remaining stall cycles of an outstanding multiply
    int       mc   [2] = '{4, 1};
    int       busy [2];
    bit [2:0] m_alu[2];
    bit       m_vld[2];
    bit       m_ill[2];
    bit       m_st [2];

    always #5 clk = ~clk;

    alu_ctrl_seq #(.MUL_CYCLES(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(rdy4),
        .funct_i(funct), .ALUOp_i(aluop), .flush_i(flush),
        .ALUCtrl_o(alu4), .ctrl_valid_o(vld4), .illegal_o(ill4),
        .mul_start_o(st4), .stall_o(stl4)
    );

    alu_ctrl_seq #(.MUL_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(rdy1),
        .funct_i(funct), .ALUOp_i(aluop), .flush_i(flush),
        .ALUCtrl_o(alu1), .ctrl_valid_o(vld1), .illegal_o(ill1),
        .mul_start_o(st1), .stall_o(stl1)
    );

    task automatic ref_decode(input bit [1:0] op, input bit [9:0] f,
                              output bit [2:0] code, output bit mul, output bit ill);
        code = 3'd3; mul = 1'b0; ill = 1'b0;
        if (op == 2'd0)      code = 3'd3;
        else if (op == 2'd1) code = 3'd4;
        else if (op == 2'd2) begin
            if      (f == 10'h007) code = 3'd0;
            else if (f == 10'h004) code = 3'd1;
            else if (f == 10'h001) code = 3'd2;
            else if (f == 10'h000) code = 3'd3;
            else if (f == 10'h100) code = 3'd4;
            else if (f == 10'h008) begin code = 3'd5; mul = 1'b1; end
            else ill = 1'b1;
        end else begin
            if ((f % 8) == 0)      code = 3'd3;
            else if (f == 10'h105) code = 3'd6;
            else ill = 1'b1;
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input bit [1:0] op,
                              input bit [9:0] f, input bit fl);
        bit [2:0] code;
        bit       mul, ill;
        ref_decode(op, f, code, mul, ill);
        for (int k = 0; k < 2; k++) begin
            m_st[k]  = 1'b0;
            m_ill[k] = 1'b0;
            m_vld[k] = 1'b0;
            if (r) begin
                busy[k]  = 0;
                m_alu[k] = 3'd3;
            end else if (busy[k] > 0) begin
                if (fl) busy[k] = 0;
                else begin
                    busy[k]  = busy[k] - 1;
                    m_vld[k] = (busy[k] == 0);
                end
            end else if (v && !fl) begin
                m_alu[k] = code;
                if (mul) begin
                    busy[k] = mc[k];
                    m_st[k] = 1'b1;
                end else begin
                    m_vld[k] = 1'b1;
                    m_ill[k] = ill;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_dut(input int k, input logic rdy, input logic [2:0] alu,
                             input logic v, input logic il, input logic s, input logic stl);
        string p;
        p = $sformatf("m%0d_", mc[k]);
        check({p, "ready"},   {3'b0, rdy}, {3'b0, (busy[k] == 0) && !rst});
        check({p, "aluctrl"}, {1'b0, alu}, {1'b0, m_alu[k]});
        check({p, "cvalid"},  {3'b0, v},   {3'b0, m_vld[k]});
        check({p, "illegal"}, {3'b0, il},  {3'b0, m_ill[k]});
        check({p, "mulst"},   {3'b0, s},   {3'b0, m_st[k]});
        check({p, "stall"},   {3'b0, stl}, {3'b0, busy[k] > 0});
    endtask

    task automatic step(input bit r, input bit v, input bit [1:0] op,
                        input bit [9:0] f, input bit fl);
        rst = r; valid = v; aluop = op; funct = f; flush = fl;
        @(negedge clk);
        check_dut(0, rdy4, alu4, vld4, ill4, st4, stl4);
        check_dut(1, rdy1, alu1, vld1, ill1, st1, stl1);
        @(posedge clk);
        model_edge(r, v, op, f, fl);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 2'd0, 10'h000, 0);
    endtask

    bit [9:0] picks[10] = '{10'h000, 10'h100, 10'h007, 10'h004, 10'h001,
                            10'h008, 10'h105, 10'h3FF, 10'h005, 10'h3F8};

    initial begin
        rst = 1'b1; valid = 1'b0; flush = 1'b0; funct = '0; aluop = '0;
        @(posedge clk);
        model_edge(1, 0, 2'd0, 10'h000, 0);
        #1;
        step(1, 0, 2'd0, 10'h000, 0);
        idle(1);

        // back-to-back R-type
        step(0, 1, 2'd2, 10'h000, 0);
        step(0, 1, 2'd2, 10'h100, 0);
        step(0, 1, 2'd2, 10'h007, 0);
        idle(2);

        // reset for two cycles in the middle of traffic
        step(0, 1, 2'd2, 10'h004, 0);
        step(1, 1, 2'd2, 10'h001, 0);
        step(1, 1, 2'd1, 10'h000, 1);
        step(0, 1, 2'd1, 10'h000, 0);
        idle(1);

        // MUL with an ADD request held on valid_i
        step(0, 1, 2'd2, 10'h008, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 2'd0, 10'h000, 0);
        idle(2);

        // flush during the busy window
        step(0, 1, 2'd2, 10'h008, 0);
        step(0, 0, 2'd0, 10'h000, 0);
        step(0, 0, 2'd0, 10'h000, 1);
        idle(7);

        // flush while idle blocks acceptance
        step(0, 1, 2'd2, 10'h004, 1);
        idle(1);

        // illegal and I-type encodings
        step(0, 1, 2'd2, 10'h3FF, 0);
        step(0, 1, 2'd3, 10'h005, 0);
        step(0, 1, 2'd3, 10'h105, 0);
        step(0, 1, 2'd3, 10'h3F8, 0);
        idle(2);

        // reset in the cycle after a MUL accept, then a clean MUL
        step(0, 1, 2'd2, 10'h008, 0);
        step(1, 0, 2'd0, 10'h000, 0);
        idle(3);
        step(0, 1, 2'd2, 10'h008, 0);
        idle(6);

        for (int i = 0; i < 600; i++) begin
            bit       r, v, fl;
            bit [1:0] op;
            bit [9:0] f;
            r  = ($urandom % 60) == 0;
            v  = ($urandom % 4) != 0;
            fl = ($urandom % 12) == 0;
            op = 2'($urandom % 4);
            f  = (($urandom % 4) == 0) ? 10'($urandom) : picks[$urandom % 10];
            step(r, v, op, f, fl);
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Parametrised, registered successor to the single-cycle ALU control decoder.
- Decodes {funct7,funct3} and ALUOp into a 3-bit ALU control code.
- Adds a valid/ready handshake, an illegal-instruction flag and a flush.
- Sequences a multi-cycle MUL: asserts stall and holds the control code until the multiplier latency has elapsed.
- Sits between the decode stage and the ALU/multiplier; its stall output feeds the PC/pipeline hold logic.

Parameters:
- MUL_CYCLES, 4, multiplier latency in cycles. Legal range 1..15.
- CNT_W, $clog2(MUL_CYCLES+1), derived localparam: width of the busy counter.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  decode request present.
- ready_o  out  1  block can accept a request; equals (state==IDLE) && !rst_i.
- funct_i  in  10  {funct7[6:0], funct3[2:0]}.
- ALUOp_i  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type.
- flush_i  in  1  abort the current operation.
- ALUCtrl_o  out  3  registered ALU control code.
- ctrl_valid_o  out  1  one-cycle pulse: ALUCtrl_o/illegal_o are valid for a completed operation.
- illegal_o  out  1  unsupported encoding; meaningful only while ctrl_valid_o=1.
- mul_start_o  out  1  one-cycle pulse that launches the multiplier.
- stall_o  out  1  high during the whole MUL busy window.

Behaviour:
- ALU codes: AND 000, XOR 001, SLL 010, ADD 011, SUB 100, MUL 101, SRA 110; 111 is reserved and never driven.
- Decode table:
  - ALUOp 00 -> ADD.
  - ALUOp 01 -> SUB.
  - ALUOp 10:
    - 0x007 -> AND
    - 0x004 -> XOR
    - 0x001 -> SLL
    - 0x000 -> ADD
    - 0x100 -> SUB
    - 0x008 -> MUL
  - ALUOp 11:
    - funct3 000 -> ADD; funct7 is ignored because it holds immediate bits.
    - funct_i 0x105 -> SRA.
  - Any other encoding -> ALUCtrl ADD with illegal_o=1.
- Reset, while rst_i=1 and in the cycle after:
  - state=IDLE, counter=0.
  - ALUCtrl_o=011; ctrl_valid_o, illegal_o, mul_start_o and stall_o all 0.
  - rst_i overrides flush_i and valid_i, and aborts BUSY immediately.
- States are IDLE and BUSY.
- Accept occurs at edge T when valid_i && ready_o && !flush_i.
- Non-MUL accept, at T+1:
  - ALUCtrl_o = decoded code, illegal_o = flag, ctrl_valid_o=1 for 1 cycle.
  - State stays IDLE, so back-to-back accepts give one result per cycle.
- MUL accept, at T+1:
  - ALUCtrl_o=101, mul_start_o=1 for 1 cycle, stall_o=1.
  - State goes to BUSY with counter=MUL_CYCLES-1.
- In BUSY:
  - ready_o=0 and valid_i is ignored; ALUCtrl_o is held.
  - The counter decrements each edge.
  - At the edge where counter==0: state=IDLE, stall_o=0, ctrl_valid_o=1 for that cycle, illegal_o=0.
  - Accept-to-ctrl_valid latency is MUL_CYCLES+1. With MUL_CYCLES=1 it is 2.
- The first new accept is possible at the edge that ends the ctrl_valid_o cycle.
- flush_i:
  - In BUSY: next state IDLE, stall_o=0, no ctrl_valid_o. ALUCtrl_o keeps its last value.
  - In IDLE: blocks acceptance and suppresses a pending ctrl_valid_o for the next cycle.
- When no accept occurs in IDLE, ctrl_valid_o, mul_start_o and illegal_o return to 0; ALUCtrl_o holds its value.
- The counter never wraps. CNT_W must hold MUL_CYCLES-1.

Decomposition:
- Shared header/package (alu_pkg):
  - funct_* and funct3_* encodings.
  - ALU_* 3-bit codes.
  - ALUOp codes.
  - IDLE/BUSY state encodings.
- One combinational sub-module, alu_ctrl_decode:
  - Inputs: funct_i, ALUOp_i.
  - Outputs: code[2:0], is_mul, illegal.
  - Reused by later pipelined cores.
- alu_ctrl_seq contains the handshake, FSM, counter and output registers.

Test Plan:
1. Reset: rst_i=1 for 2 cycles mid-stream -> ALUCtrl_o=011, all pulses 0, stall_o=0; ready_o=1 the first cycle after rst_i drops.
2. Back-to-back R-type: ALUOp=10 with funct 0x000, 0x100, 0x007 on consecutive cycles -> ALUCtrl_o=011, 100, 000 on T+1..T+3; ctrl_valid_o high 3 cycles; illegal_o=0.
3. MUL, MUL_CYCLES=4: funct 0x008 accepted at T, with an ADD request held on valid_i -> mul_start_o at T+1; stall_o T+1..T+4; ready_o=0 T+1..T+4; ctrl_valid_o with 101 at T+5; ADD accepted at the T+5 edge and output 011 at T+6.
4. Flush mid-MUL: flush_i=1 at T+2 -> stall_o=0 from T+3, ready_o=1, no ctrl_valid_o through T+8.
5. Illegal encodings: (10, 0x3FF) and (11, 0x005) -> ALUCtrl_o=011, illegal_o=1; (11, 0x105) -> 110, illegal_o=0; (11, 0x3F8) -> 011, illegal_o=0.
6. Reset mid-MUL with MUL_CYCLES=1: accept at T, rst_i at T+1 -> no ctrl_valid_o; IDLE, outputs at reset values from T+2; a MUL without reset gives ctrl_valid_o at T+2.
